regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file, successor to the 2R/2W core regfile.
//  Configurable read/write port counts, write-port priority, optional same-cycle write->read bypass.
//  Reset clears the array with a one-register-per-cycle sweep, so the array maps to RAM/LUTRAM.
//  Sits between decode (read ports) and writeback (port 0 = load/ALU result, port 1+ = addr writeback).
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; depth = 2**ADDR_W
//  NREAD    2   number of read ports (>=1)
//  NWRITE   2   number of write ports (>=1); lower index = higher priority
//  BYPASS   1   1: a same-cycle write is forwarded into rdata; 0: rdata shows the pre-write array
//  RET_REG  3   register exposed on ret_val (compiler return-value register)
// PORTS
//  clk      in   1              clock, rising edge
//  rst      in   1              synchronous active-high reset
//  clk_en   in   1              global advance enable; when 0, no state changes (except rst)
//  stall    in   1              1: hold all rdata registers
//  raddr    in   NREAD*ADDR_W   read addresses; port r = raddr[r*ADDR_W +: ADDR_W]
//  rdata    out  NREAD*DATA_W   registered read data, same packing as raddr
//  wen      in   NWRITE         per-port write enable
//  waddr    in   NWRITE*ADDR_W  write addresses, packed as raddr
//  wdata    in   NWRITE*DATA_W  write data, packed as rdata
//  init_done out 1              1: sweep complete, ports live
//  ret_val  out  DATA_W         combinational copy of reg[RET_REG]
// BEHAVIOUR
//  Reset: rst=1 (sampled at posedge, regardless of clk_en) -> state INIT, sweep cnt=0, rdata=0, init_done=0.
//  INIT: each clk_en cycle writes 0 to reg[cnt], cnt++. After reg[2**ADDR_W-1] is cleared -> RUN
//   and init_done=1 on the following edge. Sweep takes 2**ADDR_W enabled cycles.
//   During INIT: wen ignored, rdata held at 0, ret_val forced 0.
//  rst asserted mid-sweep or in RUN: restarts the sweep at cnt=0. Already-cleared entries are cleared again.
//  RUN state is terminal until rst.
//  Writes (RUN, clk_en=1): each port p with wen[p]=1 and waddr[p]!=0 writes at posedge.
//   If several enabled ports hit one address, the lowest p wins; the others are dropped.
//   Writes to address 0 are discarded.
//  Reads (RUN, clk_en=1, stall=0), per port r, at posedge:
//   rdata[r] <= 0                   if raddr[r]==0
//            <= wdata[winning p]    if BYPASS=1 and an enabled write hits raddr[r]
//            <= reg[raddr[r]]       otherwise (pre-write value when BYPASS=0)
//   Read latency is 1 cycle.
//  stall=1 or clk_en=0: rdata holds. Writes still occur when stall=1 and clk_en=1.
//  ret_val: reg[RET_REG] combinationally; reflects a write the cycle after its posedge.
//  Widths: no arithmetic; address compares use the full ADDR_W; no truncation.
// TESTING
//  1 rst 1 cycle, ADDR_W=5 -> init_done=0 for exactly 32 clk_en cycles then 1; all reads return 0.
//  2 rst mid-sweep at cnt=10 -> cnt restarts; init_done rises 32 enabled cycles after the second rst.
//  3 wen=2'b11, waddr0=waddr1=7, wdata0=0xAAAA, wdata1=0x5555 -> reg7=0xAAAA.
//    Same cycle, waddr1=8 -> reg8=0x5555.
//  4 BYPASS=1: write r5=0x1234 while raddr0=5 -> rdata0=0x1234 next cycle.
//    BYPASS=0: same stimulus -> rdata0 holds the old value; 0x1234 on the following read.
//  5 write r0=0xFFFF, then read r0 -> 0. Write r3=42 -> ret_val=42 after the edge.
//  6 stall=1 with raddr change and write to raddr -> rdata unchanged, write lands.
//    stall=0 -> new value appears; clk_en=0 -> no write, no read update.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port integer register file. Write ports
//                are prioritised (lower index wins), reads are registered
//                with optional same-cycle write forwarding, and the array is
//                cleared after reset by a one-entry-per-cycle sweep so it can
//                map onto RAM/LUTRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NREAD   = 2,
    parameter int NWRITE  = 2,
    parameter int BYPASS  = 1,
    parameter int RET_REG = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     stall,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    input  logic [NWRITE*DATA_W-1:0] wdata,
    output logic                     init_done,
    output logic [DATA_W-1:0]        ret_val
);

    localparam int              DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_last = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_zero = '0;
    localparam logic [ADDR_W-1:0] c_ret  = ADDR_W'(RET_REG);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic [DATA_W-1:0]   rdata_q [NREAD];
    logic [DATA_W-1:0]   rdata_d [NREAD];
    logic [DATA_W-1:0]   mem_q   [DEPTH];

    logic [ADDR_W-1:0]   w_ra [NREAD];
    logic [ADDR_W-1:0]   w_wa [NWRITE];
    logic [DATA_W-1:0]   w_wd [NWRITE];
    logic [NWRITE-1:0]   w_win;
    logic [DATA_W-1:0]   w_rd_val;

    // Unpack the flat port buses into per-port views.
    generate
        for (genvar r = 0; r < NREAD; r++) begin : g_rport
            assign w_ra[r]                       = raddr[r*ADDR_W +: ADDR_W];
            assign rdata[r*DATA_W +: DATA_W]     = rdata_q[r];
        end
        for (genvar p = 0; p < NWRITE; p++) begin : g_wport
            assign w_wa[p] = waddr[p*ADDR_W +: ADDR_W];
            assign w_wd[p] = wdata[p*DATA_W +: DATA_W];
        end
    endgenerate

    // Resolve which write ports actually land: live, non-zero address, and no
    // lower-index enabled port targeting the same register.
    always_comb begin
        w_win = '0;
        for (int p = 0; p < NWRITE; p++) begin
            w_win[p] = wen[p] && (w_wa[p] != c_zero) && (state_q == ST_RUN) && clk_en;
            for (int q = 0; q < p; q++) begin
                if (wen[q] && (w_wa[q] == w_wa[p])) begin
                    w_win[p] = 1'b0;
                end
            end
        end
    end

    // Next read data per port; winning writes are forwarded when BYPASS is set.
    always_comb begin
        w_rd_val = '0;
        for (int r = 0; r < NREAD; r++) begin
            rdata_d[r] = rdata_q[r];
            if ((state_q == ST_RUN) && clk_en && !stall) begin
                if (w_ra[r] == c_zero) begin
                    rdata_d[r] = '0;
                end else begin
                    w_rd_val = mem_q[w_ra[r]];
                    if (BYPASS != 0) begin
                        for (int p = 0; p < NWRITE; p++) begin
                            if (w_win[p] && (w_wa[p] == w_ra[r])) begin
                                w_rd_val = w_wd[p];
                            end
                        end
                    end
                    rdata_d[r] = w_rd_val;
                end
            end
        end
    end

    // Sweep sequencing: advance one entry per enabled cycle, go live after the last.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (clk_en && (state_q == ST_INIT)) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == c_last) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // Control and read-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            for (int r = 0; r < NREAD; r++) begin
                rdata_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            for (int r = 0; r < NREAD; r++) begin
                rdata_q[r] <= rdata_d[r];
            end
        end
    end

    // Register array: no reset so it can map to RAM; cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (!rst && clk_en) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= '0;
            end else begin
                for (int p = 0; p < NWRITE; p++) begin
                    if (w_win[p]) begin
                        mem_q[w_wa[p]] <= w_wd[p];
                    end
                end
            end
        end
    end

    assign init_done = init_done_q;
    assign ret_val   = (state_q == ST_RUN) ? mem_q[c_ret] : '0;

endmodule
`default_nettype wire
